// File: rtl/sddt_pkg.sv
// Shared sizing defaults for the DDR4 read-data packetizer slice.
package sddt_pkg;

    localparam int RDATA_W    = 512;
    localparam int FIFO_DEPTH = 16;
    localparam int CFG_LEN_W  = 16;

endpackage

// File: rtl/rdata_packetizer_sync_fifo.sv
// Single-clock FIFO with a registered head-of-queue read port and occupancy count.
module sync_fifo
    import sddt_pkg::*;
#(
    parameter int DATA_W = RDATA_W,
    parameter int DEPTH  = FIFO_DEPTH
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   wr_en,
    input  logic [DATA_W-1:0]      wr_data,
    input  logic                   rd_en,
    output logic [DATA_W-1:0]      rd_data,
    output logic [$clog2(DEPTH):0] count
);

    localparam int AW = $clog2(DEPTH);

    logic [DATA_W-1:0] mem_r [DEPTH];
    logic [AW-1:0]     wr_ptr_r;
    logic [AW-1:0]     rd_ptr_r;
    logic [AW-1:0]     rd_ptr_nxt_s;
    logic [AW:0]       count_r;
    logic [DATA_W-1:0] head_r;

    assign rd_ptr_nxt_s = rd_ptr_r + AW'(rd_en);

    // Storage array; contents are deliberately left unreset.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_r[wr_ptr_r] <= wr_data;
        end
    end

    // Pointers and occupancy.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_r <= {AW{1'b0}};
            rd_ptr_r <= {AW{1'b0}};
            count_r  <= {(AW+1){1'b0}};
        end else begin
            wr_ptr_r <= wr_ptr_r + AW'(wr_en);
            rd_ptr_r <= rd_ptr_nxt_s;
            count_r  <= count_r + (AW+1)'(wr_en) - (AW+1)'(rd_en);
        end
    end

    // Head register tracks the post-edge oldest entry; bypass when the write lands at the head.
    always_ff @(posedge clk) begin
        if (wr_en && (wr_ptr_r == rd_ptr_nxt_s)) begin
            head_r <= wr_data;
        end else begin
            head_r <= mem_r[rd_ptr_nxt_s];
        end
    end

    assign rd_data = head_r;
    assign count   = count_r;

endmodule

// File: rtl/rdata_packetizer.sv
// Packs DDR4 read beats into AXI-Stream packets of cfg_pkt_len beats, closed early by flush.
// Optional idle timeout closing is built when RDATA_PKT_TIMEOUT_EN is defined.
module rdata_packetizer
    import sddt_pkg::*;
#(
    parameter int DATA_W = RDATA_W,
    parameter int DEPTH  = FIFO_DEPTH,
    parameter int LEN_W  = CFG_LEN_W
) (
    input  logic                   c0_ddr4_clk,
    input  logic                   c0_ddr4_rst,
    input  logic [DATA_W-1:0]      s_axis_tdata,
    input  logic                   s_axis_tvalid,
    output logic                   s_axis_tready,
    output logic [DATA_W-1:0]      m_axis_tdata,
    output logic [DATA_W/8-1:0]    m_axis_tkeep,
    output logic                   m_axis_tlast,
    output logic                   m_axis_tvalid,
    input  logic                   m_axis_tready,
    input  logic [LEN_W-1:0]       cfg_pkt_len,
    input  logic [LEN_W-1:0]       cfg_timeout,
    input  logic                   flush,
    output logic [$clog2(DEPTH):0] fifo_count,
    output logic [31:0]            pkt_count
);

    localparam int CNT_W = $clog2(DEPTH) + 1;
    localparam logic [LEN_W-1:0] LEN_ZERO = {LEN_W{1'b0}};
    localparam logic [LEN_W-1:0] LEN_ONE  = {{(LEN_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_TWO  = {{(CNT_W-2){1'b0}}, 2'b10};

    logic             push_s, pop_s, tlast_hs_s;
    logic [CNT_W-1:0] count_s, count_nxt_s;
    logic [LEN_W-1:0] len_cfg_s, len_eff_s;
    logic [LEN_W-1:0] len_q_r, len_q_nxt_s;
    logic [LEN_W-1:0] beat_cnt_r, beat_cnt_nxt_s;
    logic             close_pend_r, close_pend_nxt_s;
    logic             close_lat_r, close_lat_nxt_s, lat_hold_s;
    logic             tvalid_r, tvalid_nxt_s, tlast_r, tlast_nxt_s;
    logic             final_nxt_s, tready_r, timeout_hit_s;
    logic [31:0]      pkt_count_r;

    assign push_s      = s_axis_tvalid & tready_r;
    assign pop_s       = tvalid_r & m_axis_tready;
    assign tlast_hs_s  = pop_s & tlast_r;
    assign count_nxt_s = count_s + CNT_W'(push_s) - CNT_W'(pop_s);
    assign len_cfg_s   = (cfg_pkt_len == LEN_ZERO) ? LEN_ONE : cfg_pkt_len;

    sync_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_fifo (
        .clk     (c0_ddr4_clk),
        .rst     (c0_ddr4_rst),
        .wr_en   (push_s),
        .wr_data (s_axis_tdata),
        .rd_en   (pop_s),
        .rd_data (m_axis_tdata),
        .count   (count_s)
    );

    // Outputs are registered from the post-edge state, so valid/last line up with the head beat.
    always_comb begin
        len_q_nxt_s      = len_q_r;
        beat_cnt_nxt_s   = beat_cnt_r;
        close_pend_nxt_s = close_pend_r;
        if (pop_s && (beat_cnt_r == LEN_ZERO)) begin
            len_q_nxt_s = len_cfg_s;
        end else begin
            len_q_nxt_s = len_q_r;
        end
        if (tlast_hs_s) begin
            beat_cnt_nxt_s = LEN_ZERO;
        end else if (pop_s) begin
            beat_cnt_nxt_s = beat_cnt_r + LEN_ONE;
        end else begin
            beat_cnt_nxt_s = beat_cnt_r;
        end
        if (tlast_hs_s) begin
            close_pend_nxt_s = 1'b0;
        end else if ((flush && (count_s != CNT_ZERO)) || timeout_hit_s) begin
            close_pend_nxt_s = 1'b1;
        end else begin
            close_pend_nxt_s = close_pend_r;
        end
        // Before its first pop a packet has not latched a length yet; the live config governs it.
        len_eff_s   = (beat_cnt_nxt_s == LEN_ZERO) ? len_cfg_s : len_q_nxt_s;
        final_nxt_s = (beat_cnt_nxt_s == (len_eff_s - LEN_ONE));
        lat_hold_s  = close_lat_r & ~pop_s;
        if (count_nxt_s >= CNT_TWO) begin
            tvalid_nxt_s = 1'b1;
        end else if (count_nxt_s == CNT_ONE) begin
            tvalid_nxt_s = final_nxt_s | close_pend_nxt_s | lat_hold_s;
        end else begin
            tvalid_nxt_s = 1'b0;
        end
        close_lat_nxt_s = lat_hold_s |
                          (tvalid_nxt_s & (count_nxt_s == CNT_ONE) & close_pend_nxt_s);
        tlast_nxt_s     = tvalid_nxt_s & (final_nxt_s | close_lat_nxt_s);
    end

    // Packet state, output handshake registers and packet counter.
    always_ff @(posedge c0_ddr4_clk) begin
        if (c0_ddr4_rst) begin
            len_q_r      <= LEN_ONE;
            beat_cnt_r   <= LEN_ZERO;
            close_pend_r <= 1'b0;
            close_lat_r  <= 1'b0;
            tvalid_r     <= 1'b0;
            tlast_r      <= 1'b0;
            tready_r     <= 1'b0;
            pkt_count_r  <= 32'd0;
        end else begin
            len_q_r      <= len_q_nxt_s;
            beat_cnt_r   <= beat_cnt_nxt_s;
            close_pend_r <= close_pend_nxt_s;
            close_lat_r  <= close_lat_nxt_s;
            tvalid_r     <= tvalid_nxt_s;
            tlast_r      <= tlast_nxt_s;
            tready_r     <= (count_nxt_s < CNT_W'(DEPTH));
            pkt_count_r  <= pkt_count_r + {31'd0, tlast_hs_s};
        end
    end

`ifdef RDATA_PKT_TIMEOUT_EN
    logic [LEN_W-1:0] idle_cnt_r, idle_cnt_nxt_s, idle_inc_s;

    assign idle_inc_s = idle_cnt_r + LEN_ONE;

    // Idle run length while a lone non-closed beat waits with no new arrivals.
    always_comb begin
        idle_cnt_nxt_s = LEN_ZERO;
        timeout_hit_s  = 1'b0;
        if (!push_s && (count_s == CNT_ONE) && !close_pend_r && (cfg_timeout != LEN_ZERO)) begin
            idle_cnt_nxt_s = idle_inc_s;
            timeout_hit_s  = (idle_inc_s == cfg_timeout);
        end else begin
            idle_cnt_nxt_s = LEN_ZERO;
            timeout_hit_s  = 1'b0;
        end
    end

    // Idle counter register.
    always_ff @(posedge c0_ddr4_clk) begin
        if (c0_ddr4_rst) begin
            idle_cnt_r <= LEN_ZERO;
        end else begin
            idle_cnt_r <= idle_cnt_nxt_s;
        end
    end
`else
    logic unused_cfg_timeout_s;

    assign unused_cfg_timeout_s = ^cfg_timeout;
    assign timeout_hit_s        = 1'b0;
`endif

    assign s_axis_tready = tready_r;
    assign m_axis_tvalid = tvalid_r;
    assign m_axis_tlast  = tlast_r;
    assign m_axis_tkeep  = {(DATA_W/8){1'b1}};
    assign fifo_count    = count_s;
    assign pkt_count     = pkt_count_r;

endmodule

// File: tb/tb_rdata_packetizer.sv
// Randomized bench for rdata_packetizer against a queue-based packet model.
module tb_rdata_packetizer;

    logic         clk = 1'b0;
    logic         rst;
    logic [511:0] s_tdata;
    logic         s_tvalid;
    logic         s_tready;
    logic [511:0] m_tdata;
    logic [63:0]  m_tkeep;
    logic         m_tlast;
    logic         m_tvalid;
    logic         m_tready;
    logic [15:0]  cfg_len;
    logic [15:0]  cfg_timeout;
    logic         flush;
    logic [4:0]   fifo_count;
    logic [31:0]  pkt_count;

    always #5 clk = ~clk;

    rdata_packetizer dut (
        .c0_ddr4_clk   (clk),
        .c0_ddr4_rst   (rst),
        .s_axis_tdata  (s_tdata),
        .s_axis_tvalid (s_tvalid),
        .s_axis_tready (s_tready),
        .m_axis_tdata  (m_tdata),
        .m_axis_tkeep  (m_tkeep),
        .m_axis_tlast  (m_tlast),
        .m_axis_tvalid (m_tvalid),
        .m_axis_tready (m_tready),
        .cfg_pkt_len   (cfg_len),
        .cfg_timeout   (cfg_timeout),
        .flush         (flush),
        .fifo_count    (fifo_count),
        .pkt_count     (pkt_count)
    );

    typedef struct {
        logic [511:0] data;
        logic         last;
    } beat_t;

    beat_t        pend[$];
    int           pos, cur_plen, exp_pkts;
    int           errors, checks, cyc;
    int           last_push_cyc, last_pop_cyc;
    bit           pushed, stall_prev;
    logic [511:0] hold_data;
    logic         hold_last;
    logic         nx_rst, nx_valid, nx_ready, nx_flush;
    logic [511:0] nx_data;

    task automatic check_val(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [511:0] rand_beat();
        logic [511:0] d;
        for (int k = 0; k < 16; k++) d[k*32 +: 32] = $urandom;
        return d;
    endfunction

    // One clock: drive at the falling edge, predict the handshakes of the next rising edge.
    task automatic cycle();
        beat_t b;
        @(negedge clk);
        rst      = nx_rst;
        s_tvalid = nx_valid;
        s_tdata  = nx_data;
        m_tready = nx_ready;
        flush    = nx_flush;
        pushed   = 1'b0;
        if (stall_prev) begin
            check_val("hold_valid", m_tvalid, 1'b1);
            check_val("hold_data", m_tdata, hold_data);
            check_val("hold_last", m_tlast, hold_last);
        end
        if (nx_rst) begin
            pend.delete();
            pos        = 0;
            exp_pkts   = 0;
            stall_prev = 1'b0;
        end else begin
            if (flush && pend.size() > 0) begin
                b = pend.pop_back();
                b.last = 1'b1;
                pend.push_back(b);
                pos = 0;
            end
            if (m_tvalid && m_tready) begin
                if (pend.size() == 0) begin
                    check_val("pop_when_empty", m_tvalid, 1'b0);
                end else begin
                    b = pend.pop_front();
                    check_val("tdata", m_tdata, b.data);
                    check_val("tlast", m_tlast, b.last);
                    if (b.last) begin
                        exp_pkts++;
                        last_pop_cyc = cyc;
                    end
                end
            end
            if (s_tvalid && s_tready) begin
                pushed = 1'b1;
                if (pos == 0) cur_plen = (cfg_len == 16'd0) ? 1 : int'(cfg_len);
                b.data = s_tdata;
                b.last = (pos == cur_plen - 1);
                pos    = b.last ? 0 : pos + 1;
                pend.push_back(b);
                last_push_cyc = cyc;
            end
            stall_prev = m_tvalid && !m_tready;
            hold_data  = m_tdata;
            hold_last  = m_tlast;
        end
        cyc++;
    endtask

    task automatic idle_cycles(input int n, input logic rdy);
        nx_valid = 1'b0;
        nx_flush = 1'b0;
        nx_ready = rdy;
        repeat (n) cycle();
    endtask

    // mode 0: sink stalled, 1: sink ready, 2: random sink and random source gaps
    task automatic send(input int n, input int mode);
        int tries;
        for (int i = 0; i < n; i++) begin
            nx_valid = 1'b1;
            nx_data  = rand_beat();
            tries    = 0;
            do begin
                nx_ready = (mode == 2) ? ($urandom_range(0, 2) != 0) : (mode == 1);
                cycle();
                tries++;
            end while (!pushed && tries < 200);
            if (!pushed) check_val("push_stuck", s_tready, 1'b1);
            if (mode == 2 && $urandom_range(0, 3) == 0) begin
                nx_valid = 1'b0;
                cycle();
            end
        end
        nx_valid = 1'b0;
    endtask

    task automatic do_flush();
        nx_valid = 1'b0;
        nx_flush = 1'b1;
        cycle();
        nx_flush = 1'b0;
    endtask

    task automatic reset_seq();
        nx_rst   = 1'b1;
        nx_valid = 1'b0;
        nx_flush = 1'b0;
        cycle();
        cycle();
        check_val("rst_tvalid", m_tvalid, 1'b0);
        check_val("rst_tlast", m_tlast, 1'b0);
        check_val("rst_tready", s_tready, 1'b0);
        check_val("rst_fifo_count", fifo_count, 5'd0);
        check_val("rst_pkt_count", pkt_count, 32'd0);
        nx_rst = 1'b0;
        cycle();
        cycle();
        check_val("post_rst_tready", s_tready, 1'b1);
    endtask

    initial begin
        logic [511:0] arr [20];
        int idx, n;
        errors = 0; checks = 0; cyc = 0; pos = 0; cur_plen = 1; exp_pkts = 0;
        stall_prev = 1'b0; pushed = 1'b0;
        rst = 1'b1; s_tvalid = 1'b0; s_tdata = '0; m_tready = 1'b0; flush = 1'b0;
        nx_rst = 1'b1; nx_valid = 1'b0; nx_ready = 1'b0; nx_flush = 1'b0; nx_data = '0;
        cfg_len = 16'd4; cfg_timeout = 16'd0;

        reset_seq();
        check_val("tkeep", m_tkeep, {64{1'b1}});

        // Two full packets back to back.
        send(8, 1);
        idle_cycles(6, 1'b1);
        check_val("b2b_pkt_count", pkt_count, exp_pkts);
        check_val("b2b_fifo_count", fifo_count, pend.size());

        // Partial packet closed by flush, then a full one.
        send(3, 1);
        idle_cycles(6, 1'b1);
        check_val("partial_waiting", fifo_count, pend.size());
        do_flush();
        idle_cycles(6, 1'b1);
        send(4, 1);
        idle_cycles(6, 1'b1);
        check_val("flush_pkt_count", pkt_count, exp_pkts);

        // Fill to depth with the sink stalled, then release.
        for (int i = 0; i < 20; i++) arr[i] = rand_beat();
        idx = 0;
        for (int c = 0; c < 80 && idx < 20; c++) begin
            nx_valid = 1'b1;
            nx_data  = arr[idx];
            nx_ready = (c >= 20);
            cycle();
            if (pushed) idx++;
            if (c == 19) begin
                check_val("full_accepted", idx, 16);
                check_val("full_count", fifo_count, 5'd16);
                check_val("full_ready", s_tready, 1'b0);
            end
        end
        idle_cycles(20, 1'b1);
        check_val("fill_all_in", idx, 20);
        check_val("fill_pkt_count", pkt_count, exp_pkts);
        check_val("fill_empty", fifo_count, 5'd0);

        // Reset in the middle of a packet.
        send(2, 0);
        reset_seq();
        send(4, 1);
        idle_cycles(8, 1'b1);
        check_val("rst_mid_pkt_count", pkt_count, exp_pkts);
        check_val("rst_mid_one_pkt", exp_pkts, 1);

`ifdef RDATA_PKT_TIMEOUT_EN
        cfg_len     = 16'd8;
        cfg_timeout = 16'd10;
        send(5, 1);
        begin
            beat_t b;
            b = pend.pop_back();
            b.last = 1'b1;
            pend.push_back(b);
            pos = 0;
        end
        idle_cycles(30, 1'b1);
        check_val("timeout_latency", ((last_pop_cyc - last_push_cyc) >= 10) &&
                                     ((last_pop_cyc - last_push_cyc) <= 13), 1'b1);
        check_val("timeout_pkt_count", pkt_count, exp_pkts);
        cfg_timeout = 16'd0;
`endif

        // Random traffic, lengths and flushes.
        for (int r = 0; r < 40; r++) begin
            if (pend.size() == 0) cfg_len = 16'($urandom_range(0, 5));
            n = $urandom_range(1, 12);
            send(n, 2);
            idle_cycles(20, 1'b1);
            if ($urandom_range(0, 1) == 1) do_flush();
            idle_cycles(4, 1'b1);
            check_val("rnd_fifo_count", fifo_count, pend.size());
            check_val("rnd_pkt_count", pkt_count, exp_pkts);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/rdata_packetizer.md
RDATA_PACKETIZER -- requirements
Module: rdata_packetizer

Interface
REQ-001 DATA_W, 512, data width in bits; multiple of 8.
REQ-002 DEPTH, 16, FIFO entries; power of 2, >=4.
REQ-003 LEN_W, 16, width of cfg_pkt_len and cfg_timeout.
REQ-004 c0_ddr4_clk  input  1  sole clock; all state on rising edge.
REQ-005 c0_ddr4_rst  input  1  reset; synchronous, active-high.
REQ-006 s_axis_tdata  input  DATA_W  read beat from the core.
REQ-007 s_axis_tvalid  input  1  read beat valid.
REQ-008 s_axis_tready  output  1  FIFO can accept a beat.
REQ-009 m_axis_tdata  output  DATA_W  beat to the DMA S2MM channel.
REQ-010 m_axis_tkeep  output  DATA_W/8  byte enables; all ones.
REQ-011 m_axis_tlast  output  1  final beat of a packet.
REQ-012 m_axis_tvalid  output  1  output beat valid.
REQ-013 m_axis_tready  input  1  DMA accepts the beat.
REQ-014 cfg_pkt_len  input  LEN_W  beats per packet; 0 is treated as 1.
REQ-015 cfg_timeout  input  LEN_W  idle cycles before a partial packet closes; 0 disables.
REQ-016 flush  input  1  one-cycle pulse; closes the open packet.
REQ-017 fifo_count  output  $clog2(DEPTH)+1  current FIFO occupancy.
REQ-018 pkt_count  output  32  completed packets (tlast handshakes); wraps mod 2^32.

Function
REQ-019 Push when s_axis_tvalid&&s_axis_tready; s_axis_tready=(count<DEPTH) from registered count only, so no pop-to-ready combinational path; full with simultaneous pop deasserts ready.
REQ-020 Pop when m_axis_tvalid&&m_axis_tready; simultaneous push and pop leaves count unchanged; data order is strict FIFO.
REQ-021 len_q latches cfg_pkt_len (0->1) at the first pop of each packet (beat_cnt==0); mid-packet cfg changes apply to the next packet only.
REQ-022 beat_cnt counts popped beats in the open packet; it resets to 0 on a tlast handshake.
REQ-023 Lookahead rule: m_axis_tvalid=1 if count>=2, or if count==1 and (beat_cnt==len_q-1, or close_pend, or close_lat); a non-final beat is never sent without a successor queued.
REQ-024 Invariant: beat_cnt>0 implies count>=1.
REQ-025 m_axis_tlast=(beat_cnt==len_q-1)|close_lat.
REQ-026 close_lat sets when m_axis_tvalid, count==1 and close_pend are all true; it clears on handshake.
REQ-027 Under back-pressure, tdata/tlast/tvalid are held stable until handshake (AXIS rule), including while beats arrive.
REQ-028 flush sets close_pend when count>0; otherwise it is ignored; flush coincident with a tlast handshake is ignored.
REQ-029 A tlast handshake clears close_pend, increments pkt_count and ends the packet; a single-beat packet is legal.
REQ-030 Latency: a final beat appears 1 cycle after the push that makes it eligible (registered FIFO read).

Reset
REQ-031 On reset: count=0, beat_cnt=0, close_pend=close_lat=0, idle_cnt=0, pkt_count=0, m_axis_tvalid=0, m_axis_tlast=0, s_axis_tready=0 for the reset cycle, then 1.
REQ-032 Reset mid-packet discards FIFO contents with no tlast emitted; FIFO RAM contents are not reset.

Configuration
REQ-033 With RDATA_PKT_TIMEOUT_EN: idle_cnt counts cycles with count==1, no push, !close_pend; a push clears it; reaching cfg_timeout (nonzero) sets close_pend.
REQ-034 Without the macro: idle_cnt is not built, cfg_timeout is unused, and only len_q or flush closes packets.

Structure
REQ-035 sddt_pkg holds RDATA_W=512, the default DEPTH, and the LEN_W default.
REQ-036 One sub-module, sync_fifo (DATA_W x DEPTH, registered read, count output).

Verification
REQ-037 len=4, 8 back-to-back beats, tready=1 -> 2 packets, tlast on beats 4 and 8, pkt_count=2.
REQ-038 len=4, 3 beats then flush -> tlast on beat 3, pkt_count=1; next 4 beats form a full packet.
REQ-039 Macro on, timeout=10, len=8, 5 beats then idle -> tlast on beat 5, 11+/-1 cycles after the last push.
REQ-040 DEPTH=16, tready=0, 20 beats offered -> s_axis_tready drops after 16; release -> all 20 in order, tdata stable while stalled.
REQ-041 Reset asserted after 2 of 4 beats -> outputs at reset values; 4 new beats -> one clean packet, pkt_count=1.
